// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall scheduler: StallBus vectors,
// mult/div FSM state encoding and default EX-occupancy latencies.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  // Bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = stop.
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_LU   = 6'b000111;
  localparam stall_bus_t STALL_MD   = 6'b001111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int DIV_LAT_DEF = 33;
  localparam int MUL_LAT_DEF = 1;

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard detect: the ID instruction reads a register that a load in EX
// has not produced yet. $0 is hardwired and never creates a hazard.
module load_use_detect (
  input  logic       ex_is_load,
  input  logic       ex_rf_we,
  input  logic [4:0] ex_rf_waddr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_rs_used && (id_rs == ex_rf_waddr);
  assign rt_hit   = id_rt_used && (id_rt == ex_rf_waddr);
  assign load_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler: merges load-use and multi-cycle mult/div hazards into
// one StallBus, sequences mult/div occupancy of EX, and counts stall cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               ex_is_load,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_md_req,
  input  logic               ex_md_is_div,
  output logic [STALL_W-1:0] stall,
  output logic               md_busy,
  output logic               md_done,
  output logic [31:0]        perf_lu_cnt,
  output logic [31:0]        perf_md_cnt
);

  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

  logic             load_use;
  logic             md_stall;
  stall_bus_t       stall_vec;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      perf_lu_q, perf_lu_d;
  logic [31:0]      perf_md_q, perf_md_d;

  load_use_detect u_load_use_detect (
    .ex_is_load  (ex_is_load),
    .ex_rf_we    (ex_rf_we),
    .ex_rf_waddr (ex_rf_waddr),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .load_use    (load_use)
  );

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (ex_md_req) begin
          state_d = MD_RUN;
          cnt_d   = ex_md_is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // The request cycle itself stalls, before the FSM has left IDLE.
  assign md_stall = ((state_q == MD_IDLE) && ex_md_req) || (state_q == MD_RUN);

  always_comb begin
    stall_vec = STALL_NONE;
    if (rst || flush)  stall_vec = STALL_NONE;
    else if (md_stall) stall_vec = STALL_MD;
    else if (load_use) stall_vec = STALL_LU;
  end

  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_md_d = perf_md_q;
    if (stall_vec == STALL_LU) perf_lu_d = perf_lu_q + 32'd1;
    if (stall_vec == STALL_MD) perf_md_d = perf_md_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      perf_lu_q <= '0;
      perf_md_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      perf_lu_q <= perf_lu_d;
      perf_md_q <= perf_md_d;
    end
  end

  // Outputs are forced low while rst is high, ahead of the synchronous clear.
  assign stall       = stall_vec;
  assign md_busy     = !rst && (state_q == MD_RUN);
  assign md_done     = !rst && !flush && (state_q == MD_DONE);
  assign perf_lu_cnt = rst ? 32'd0 : perf_lu_q;
  assign perf_md_cnt = rst ? 32'd0 : perf_md_q;

endmodule
